// File: rtl/serial_subtractor_pkg.sv
// Shared constants and state encoding for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t FIN  = 2'd2;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor, DIFF = A - B - BIN over WIDTH cycles.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf_o.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic             br_q, br_d, bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             d_bit, bo_bit;
  logic [WIDTH-1:0] res_nxt;

  full_subtractor u_cell (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .bin_i (br_q),
    .d_o   (d_bit),
    .bout_o(bo_bit)
  );

  // New bit enters at the MSB so that after WIDTH shifts bit i lands at i.
  assign res_nxt = {d_bit, res_q[WIDTH-1:1]};

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic amsb_q, amsb_d, bmsb_q, bmsb_d, ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: if (start_i) begin
        a_d     = a_i;
        b_d     = b_i;
        br_d    = bin_i;
        res_d   = '0;
        cnt_d   = '0;
        state_d = RUN;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        amsb_d  = a_i[WIDTH-1];
        bmsb_d  = b_i[WIDTH-1];
`endif
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = bo_bit;
        res_d = res_nxt;
        cnt_d = cnt_q + CW'(1);
        // The final shift publishes straight to the outputs on entry to FIN.
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = FIN;
          diff_d  = res_nxt;
          bout_d  = bo_bit;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          ovf_d   = (amsb_q ^ bmsb_q) & (amsb_q ^ d_bit);
`endif
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      amsb_q <= 1'b0;
      bmsb_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      amsb_q <= amsb_d;
      bmsb_q <= bmsb_d;
      ovf_q  <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`endif

  assign busy_o = (state_q == RUN) || (state_q == FIN);
  assign done_o = (state_q == FIN);
  assign diff_o = diff_q;
  assign bout_o = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): expected results queued at START, checked on DONE.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done, bout;
  logic [W-1:0] diff;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  logic [9:0] sb[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .start_i(start),
    .a_i    (a),
    .b_i    (b),
    .bin_i  (bin),
    .busy_o (busy),
    .done_o (done),
    .diff_o (diff),
    .bout_o (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf_o  (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Reference: {ovf, bout, diff} from a (W+1)-bit subtraction.
  function automatic logic [9:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    logic [W:0] f;
    logic       o;
    f = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    o = (x[W-1] ^ y[W-1]) & (x[W-1] ^ f[W-1]);
    return {o, f};
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) chk("sb_unexpected_done", 32'd1, 32'd0);
      else begin
        logic [9:0] e;
        e = sb.pop_front();
        chk("diff", diff, e[7:0]);
        chk("bout", bout, e[8]);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("ovf", ovf, e[9]);
`endif
      end
    end
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    int lat, bc;
    lat = 0; bc = 0;
    @(negedge clk);
    a = x; b = y; bin = bi; start = 1'b1;
    sb.push_back(model(x, y, bi));
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (busy) bc++;
      if (done) lat = n;
      if (!busy) break;
      @(negedge clk);
    end
    chk("latency", lat, W + 1);
    chk("busy_len", bc, W + 1);
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) begin at = cyc; break; end
    end
    if (at < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t1, t2, t3, bad;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    rst_n = 1'b1;

    run_op(8'h5A, 8'h23, 1'b0);
    run_op(8'h00, 8'h01, 1'b0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (diff !== 8'hFF || bout !== 1'b1) bad++;
    end
    chk("hold_20", bad, 0);
    run_op(8'h10, 8'h0F, 1'b1);
    run_op(8'h0F, 8'h0F, 1'b1);

    // START re-pulsed mid-operation must be ignored.
    @(negedge clk);
    a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
    sb.push_back(model(8'h05, 8'h03, 1'b0));
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(t1);
    repeat (14) @(negedge clk);
    chk("repulse_sb_empty", sb.size(), 0);

    // START held high: back-to-back operations every W+2 cycles.
    @(negedge clk);
    a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
    repeat (3) sb.push_back(model(8'h5A, 8'h23, 1'b0));
    wait_done(t1);
    wait_done(t2);
    wait_done(t3);
    start = 1'b0;
    chk("period_1", t2 - t1, W + 2);
    chk("period_2", t3 - t2, W + 2);
    repeat (4) @(negedge clk);
    chk("held_sb_empty", sb.size(), 0);

    // Reset three cycles into RUN aborts with no DONE.
    @(negedge clk);
    a = 8'h81; b = 8'h11; bin = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);
    repeat (3) @(negedge clk);
    chk("abort_busy_hold", busy, 0);
    rst_n = 1'b1;
    run_op(8'h33, 8'h44, 1'b1);

    for (int i = 0; i < 6; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(1)));

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    run_op(8'h80, 8'h01, 1'b0);
    run_op(8'h7F, 8'hFF, 1'b0);
`endif

    repeat (4) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
